usb_fs_out_arb_rr: RTL
======================

# usb_fs_out_arb_rr

Registered OUT-direction arbiter between the USB full-speed protocol engine and `NUM_OUT_EPS` OUT endpoint buffers. It grants ownership of the OUT data path to one requesting endpoint at a time, round-robin. It forwards received bytes to the owner with a generated byte address, and delivers end-of-packet commit/rollback strobes. Ownership is held for a whole packet; the 64-byte full-speed payload limit is enforced.

## Interface
- `NUM_OUT_EPS`, default 1: number of OUT endpoints (N ≥ 1).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `out_ep_req`  in  N  level request per endpoint: the endpoint can accept an OUT packet.
- `out_ep_grant`  out  N  registered one-hot ownership.
- `out_ep_data_put`  out  N  per-endpoint byte write strobe.
- `out_ep_data`  out  8  registered byte, shared by all endpoints.
- `out_ep_data_addr`  out  6  byte index within the current packet.
- `out_ep_commit`  out  N  one-cycle strobe: packet good.
- `out_ep_rollback`  out  N  one-cycle strobe: packet discarded.
- `arb_out_ep_data_put`  in  1  protocol engine byte valid.
- `arb_out_ep_data`  in  8  protocol engine byte.
- `arb_out_ep_commit`  in  1  end of packet, CRC good.
- `arb_out_ep_rollback`  in  1  end of packet, CRC bad or aborted.
- `arb_out_ep_granted`  out  1  registered; any grant held. The engine NAKs when this is low.
- `arb_out_ep_overflow`  out  1  sticky; more than 64 bytes were received in the current packet.

## Operation
- State: IDLE, GRANTED. Internal state:
  - `ptr`: round-robin start index, width clog2(N), minimum 1.
  - `cnt`: accepted byte count, 7 bits, range 0..64.
  - `owner`: index of the granted endpoint.
- Reset: state IDLE, `ptr`=0, `cnt`=0, overflow=0. All outputs 0.
- IDLE:
  - If any `out_ep_req` bit is set, pick the first set bit scanning `ptr`, `ptr`+1, … wrapping at N−1→0.
  - Set `owner` and the matching grant bit, raise `arb_out_ep_granted`, go to GRANTED.
  - Inputs from the engine are ignored in IDLE: no strobes.
- GRANTED, byte put:
  - When `arb_out_ep_data_put`=1 and `cnt`<64: `out_ep_data_put[owner]`=1 next cycle, `out_ep_data`=byte, `out_ep_data_addr`=`cnt[5:0]`, then `cnt`++.
  - When `cnt`=64: the byte is dropped (no put) and `arb_out_ep_overflow` is set.
- GRANTED, end of packet:
  - On `arb_out_ep_commit`: strobe `out_ep_commit[owner]`. If overflow is set, strobe `out_ep_rollback[owner]` instead.
  - On `arb_out_ep_rollback`: strobe `out_ep_rollback[owner]`.
  - Either way, on the same edge: grant cleared, `cnt`=0, overflow cleared, `ptr`=(`owner`+1) mod N, go to IDLE.
  - If commit and rollback are asserted together, rollback wins.
- Put together with commit/rollback in the same cycle: the byte is forwarded (subject to the 64 limit) in the same cycle as the end strobe. It belongs to the packet being closed.
- Request dropped while GRANTED:
  - `cnt`=0 and no put this cycle: release with no strobes, `ptr` unchanged, go to IDLE.
  - `cnt`>0: the grant is held until commit/rollback.
- `out_ep_data_put`, `out_ep_commit` and `out_ep_rollback` are only ever asserted on the `owner` bit; all other bits stay 0.
- `out_ep_data` and `out_ep_data_addr` hold their last value when no put is active.

## Timing
- Request→grant: `out_ep_req` high before edge k → grant high after edge k. Re-grant after a release takes one IDLE cycle minimum.
- Put→forward latency: 1 cycle. Back-to-back puts are supported every cycle.
- Commit/rollback→strobe latency: 1 cycle. The grant falls on the same edge the strobe rises.
- `arb_out_ep_granted` equals `|out_ep_grant` every cycle.
- Reset mid-packet: on the next edge all outputs are 0, state is IDLE, no commit/rollback strobe is issued. The endpoint discards its partial data on seeing the grant fall without a strobe.

## Test plan
- Reset: assert `reset` for 2 cycles during GRANTED with `cnt`=5 → all outputs 0 next cycle, no strobes, `ptr`=0.
- Single endpoint, N=1: req=1 → grant after 1 edge. Put 0xA1,0xB2,0xC3 on consecutive cycles → `out_ep_data_put` 3 cycles with addr 0,1,2, one cycle late. Then commit → `out_ep_commit`=1 for one cycle, grant=0 on the same edge.
- Round-robin, N=3, req=3'b111 held: 3 packets each ended by commit → grants go 001, 010, 100, then 001 again.
- Overflow: put 65 bytes, then commit → 64 puts forwarded (addr 0..63), `arb_out_ep_overflow`=1 after byte 65, `out_ep_rollback`=1, no commit. Overflow clears at release.
- Rollback with simultaneous put, N=2: owner=1, put 0x55 with rollback in the same cycle → byte forwarded at addr `cnt`, `out_ep_rollback[1]` in the same cycle, next grant scan starts at 0.
- Request drop and idle puts:
  - Grant held, req dropped with `cnt`=0 → released next edge, no strobes.
  - Puts issued while IDLE → no `out_ep_data_put`, `cnt` stays 0.

Source files
------------

// File: rtl/usb_fs_out_arb_rr.sv
// Round-robin OUT arbiter: one endpoint owns the OUT byte path for a whole packet, bytes get a 0..63 address.
// Put and commit/rollback reach the endpoint one cycle later. The engine is throttled only by the grant, so it NAKs while no grant is held.
module usb_fs_out_arb_rr #(
    parameter int NUM_OUT_EPS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_OUT_EPS-1:0] out_ep_req,
    output logic [NUM_OUT_EPS-1:0] out_ep_grant,
    output logic [NUM_OUT_EPS-1:0] out_ep_data_put,
    output logic [7:0]             out_ep_data,
    output logic [5:0]             out_ep_data_addr,
    output logic [NUM_OUT_EPS-1:0] out_ep_commit,
    output logic [NUM_OUT_EPS-1:0] out_ep_rollback,
    input  logic                   arb_out_ep_data_put,
    input  logic [7:0]             arb_out_ep_data,
    input  logic                   arb_out_ep_commit,
    input  logic                   arb_out_ep_rollback,
    output logic                   arb_out_ep_granted,
    output logic                   arb_out_ep_overflow
);

    localparam int               PTR_W     = (NUM_OUT_EPS > 1) ? $clog2(NUM_OUT_EPS) : 1;
    localparam logic [PTR_W-1:0] LAST_EP   = PTR_W'(NUM_OUT_EPS - 1);
    localparam logic [6:0]       MAX_BYTES = 7'd64;

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [6:0]             cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [NUM_OUT_EPS-1:0] grant_q, grant_d;
    logic [NUM_OUT_EPS-1:0] put_q, put_d;
    logic [NUM_OUT_EPS-1:0] commit_q, commit_d;
    logic [NUM_OUT_EPS-1:0] rollback_q, rollback_d;
    logic [7:0]             data_q, data_d;
    logic [5:0]             addr_q, addr_d;
    logic                   granted_q, granted_d;

    logic                   hi_vld, lo_vld;
    logic [PTR_W-1:0]       hi_idx, lo_idx, pick_idx;
    logic                   owner_req;
    logic                   pkt_end;

    function automatic logic [NUM_OUT_EPS-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_OUT_EPS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_OUT_EPS; i++) begin
            v[i] = (PTR_W'(i) == idx);
        end
        return v;
    endfunction

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_OUT_EPS - 1; i >= 0; i--) begin
            if (out_ep_req[i]) begin
                lo_vld = 1'b1;
                lo_idx = PTR_W'(i);
                if (PTR_W'(i) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = PTR_W'(i);
                end
            end
        end
        pick_idx = hi_vld ? hi_idx : lo_idx;
    end

    // grant_q is the one-hot owner mask while GRANTED, so it doubles as the strobe mask.
    assign owner_req = |(out_ep_req & grant_q);
    assign pkt_end   = arb_out_ep_commit | arb_out_ep_rollback;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        grant_d    = grant_q;
        put_d      = '0;
        commit_d   = '0;
        rollback_d = '0;
        data_d     = data_q;
        addr_d     = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (lo_vld) begin
                    owner_d = pick_idx;
                    grant_d = onehot(pick_idx);
                    state_d = ST_GRANTED;
                end
            end

            ST_GRANTED: begin
                if (arb_out_ep_data_put) begin
                    if (cnt_q < MAX_BYTES) begin
                        put_d  = grant_q;
                        data_d = arb_out_ep_data;
                        addr_d = cnt_q[5:0];
                        cnt_d  = cnt_q + 7'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end

                // A byte dropped in the closing cycle still poisons the packet being committed.
                if (pkt_end) begin
                    if (arb_out_ep_rollback || ovf_d) begin
                        rollback_d = grant_q;
                    end else begin
                        commit_d = grant_q;
                    end
                    grant_d = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    ptr_d   = (owner_q == LAST_EP) ? '0 : owner_q + 1'b1;
                    state_d = ST_IDLE;
                end else if (!owner_req && (cnt_q == 7'd0) && !arb_out_ep_data_put) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        granted_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            grant_q    <= '0;
            put_q      <= '0;
            commit_q   <= '0;
            rollback_q <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            granted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            grant_q    <= grant_d;
            put_q      <= put_d;
            commit_q   <= commit_d;
            rollback_q <= rollback_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            granted_q  <= granted_d;
        end
    end

    assign out_ep_grant        = grant_q;
    assign out_ep_data_put     = put_q;
    assign out_ep_data         = data_q;
    assign out_ep_data_addr    = addr_q;
    assign out_ep_commit       = commit_q;
    assign out_ep_rollback     = rollback_q;
    assign arb_out_ep_granted  = granted_q;
    assign arb_out_ep_overflow = ovf_q;

endmodule
